// File: rtl/fu_dispatch_cdb_arbiter.sv
// Dispatch and writeback control for the out-of-order execute stage.
// Issues one instruction per cycle to the lowest-index idle FU of the
// requested type, remembers each FU's ROB tag, parks each FU result in a
// one-entry holding register and drains those registers onto NUM_CDB
// result ports under round-robin arbitration. FUs themselves live outside.
module fu_dispatch_cdb_arbiter #(
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            ROB_SIZE    = 32,
  parameter int                            OP_WIDTH    = 10,
  parameter int                            NUM_FU      = 4,
  parameter int                            NUM_CDB     = 2,
  parameter int                            FU_TYPE_W   = 2,
  parameter logic [NUM_FU*FU_TYPE_W-1:0]   FU_TYPE_MAP = {2'd2, 2'd1, 2'd0, 2'd0},
  localparam int                           TAG_W       = $clog2(ROB_SIZE)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [FU_TYPE_W-1:0]           issue_fu_type_i,
  input  logic [OP_WIDTH-1:0]            issue_op_i,
  input  logic [DATA_WIDTH-1:0]          issue_a_i,
  input  logic [DATA_WIDTH-1:0]          issue_b_i,
  input  logic [TAG_W-1:0]               issue_rob_tag_i,
  output logic [NUM_FU-1:0]              fu_start_o,
  output logic [OP_WIDTH-1:0]            fu_op_o,
  output logic [DATA_WIDTH-1:0]          fu_a_o,
  output logic [DATA_WIDTH-1:0]          fu_b_o,
  input  logic [NUM_FU-1:0]              fu_busy_i,
  input  logic [NUM_FU-1:0]              fu_done_i,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_result_i,
  input  logic [NUM_FU-1:0]              fu_exc_valid_i,
  input  logic [NUM_FU*32-1:0]           fu_exc_cause_i,
  output logic [NUM_CDB-1:0]             cdb_valid_o,
  output logic [NUM_CDB*TAG_W-1:0]       cdb_rob_tag_o,
  output logic [NUM_CDB*DATA_WIDTH-1:0]  cdb_data_o,
  output logic [NUM_CDB-1:0]             cdb_exc_valid_o,
  output logic [NUM_CDB*32-1:0]          cdb_exc_cause_o,
  output logic                           overflow_err_o
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Per-slot lifecycle: idle, executing in its FU, or holding a result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HELD = 2'd2
  } slot_e;

  slot_e                 slot_q [NUM_FU];
  slot_e                 slot_d [NUM_FU];

  logic [NUM_FU-1:0]     in_flight;
  logic [NUM_FU-1:0]     buf_valid;
  logic [NUM_FU-1:0]     eligible;
  logic [NUM_FU-1:0]     grant;

  logic [TAG_W-1:0]      tag_q       [NUM_FU];
  logic [DATA_WIDTH-1:0] buf_data_q  [NUM_FU];
  logic [NUM_FU-1:0]     buf_exc_q;
  logic [31:0]           buf_cause_q [NUM_FU];

  logic [RR_W-1:0]       rr_q;
  logic [RR_W-1:0]       rr_d;
  logic                  overflow_q;

  // Rotated position of each slot relative to rr, and how many held slots
  // precede it in that order; rank below NUM_CDB means it wins a port.
  int                    pos  [NUM_FU];
  int                    rank [NUM_FU];

  assign fu_op_o        = issue_op_i;
  assign fu_a_o         = issue_a_i;
  assign fu_b_o         = issue_b_i;
  assign overflow_err_o = overflow_q;

  // Slot state register; every slot returns to idle on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int f = 0; f < NUM_FU; f++) slot_q[f] <= S_IDLE;
    end else begin
      for (int f = 0; f < NUM_FU; f++) slot_q[f] <= slot_d[f];
    end
  end

  // Slot next-state: flush wins, otherwise start / done / grant advance it.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      slot_d[f] = slot_q[f];
      if (flush_i) begin
        slot_d[f] = S_IDLE;
      end else begin
        case (slot_q[f])
          S_IDLE:  if (fu_start_o[f]) slot_d[f] = S_EXEC;
          S_EXEC:  if (fu_done_i[f])  slot_d[f] = S_HELD;
          S_HELD:  if (grant[f])      slot_d[f] = S_IDLE;
          default: slot_d[f] = S_IDLE;
        endcase
      end
    end
  end

  // Slot outputs: occupancy flags and issue eligibility per slot.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      in_flight[f] = (slot_q[f] == S_EXEC);
      buf_valid[f] = (slot_q[f] == S_HELD);
      eligible[f]  = (FU_TYPE_MAP[f*FU_TYPE_W +: FU_TYPE_W] == issue_fu_type_i) &&
                     !fu_busy_i[f] && !in_flight[f] && !buf_valid[f];
    end
  end

  // Issue handshake and one-hot start to the lowest eligible slot.
  always_comb begin
    logic found;
    found         = 1'b0;
    fu_start_o    = '0;
    issue_ready_o = rst_ni && !flush_i && (|eligible);
    for (int f = 0; f < NUM_FU; f++) begin
      if (eligible[f] && !found) begin
        fu_start_o[f] = 1'b1;
        found         = 1'b1;
      end
    end
    if (!(issue_valid_i && issue_ready_o)) fu_start_o = '0;
  end

  // Round-robin CDB arbitration straight from the holding registers.
  always_comb begin
    int last_pos;
    int last_idx;
    last_pos        = -1;
    last_idx        = 0;
    grant           = '0;
    cdb_valid_o     = '0;
    cdb_rob_tag_o   = '0;
    cdb_data_o      = '0;
    cdb_exc_valid_o = '0;
    cdb_exc_cause_o = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      pos[f] = f - int'(rr_q);
      if (pos[f] < 0) pos[f] = pos[f] + NUM_FU;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      rank[f] = 0;
      for (int g = 0; g < NUM_FU; g++) begin
        if (buf_valid[g] && (pos[g] < pos[f])) rank[f] = rank[f] + 1;
      end
    end
    for (int f = 0; f < NUM_FU; f++) begin
      if (buf_valid[f] && (rank[f] < NUM_CDB) && !flush_i) begin
        grant[f] = 1'b1;
        if (pos[f] > last_pos) begin
          last_pos = pos[f];
          last_idx = f;
        end
      end
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (grant[f] && (rank[f] == k)) begin
          cdb_valid_o[k]                           = 1'b1;
          cdb_rob_tag_o[k*TAG_W +: TAG_W]          = tag_q[f];
          cdb_data_o[k*DATA_WIDTH +: DATA_WIDTH]   = buf_data_q[f];
          cdb_exc_valid_o[k]                       = buf_exc_q[f];
          cdb_exc_cause_o[k*32 +: 32]              = buf_cause_q[f];
        end
      end
    end
    rr_d = rr_q;
    if (|grant) rr_d = RR_W'((last_idx + 1) % NUM_FU);
  end

  // Control registers: rr pointer and sticky overflow; flush restarts rr.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_q       <= flush_i ? '0 : rr_d;
      overflow_q <= overflow_q | (!flush_i && (|(fu_done_i & buf_valid)));
    end
  end

  // Tag and result storage; only written when the owning slot accepts it.
  always_ff @(posedge clk_i) begin
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_start_o[f]) tag_q[f] <= issue_rob_tag_i;
      if (!flush_i && in_flight[f] && fu_done_i[f]) begin
        buf_data_q[f]  <= fu_result_i[f*DATA_WIDTH +: DATA_WIDTH];
        buf_exc_q[f]   <= fu_exc_valid_i[f];
        buf_cause_q[f] <= fu_exc_cause_i[f*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_fu_dispatch_cdb_arbiter.sv
// Bench for fu_dispatch_cdb_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// slot/queue model of the dispatch and writeback rules.
module tb_fu_dispatch_cdb_arbiter;

  localparam int DW   = 32;
  localparam int TW   = 5;
  localparam int OW   = 10;
  localparam int NF   = 4;
  localparam int NC   = 2;

  logic           clk_i;
  logic           rst_ni;
  logic           flush_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [1:0]     issue_fu_type_i;
  logic [OW-1:0]  issue_op_i;
  logic [DW-1:0]  issue_a_i;
  logic [DW-1:0]  issue_b_i;
  logic [TW-1:0]  issue_rob_tag_i;
  logic [NF-1:0]  fu_start_o;
  logic [OW-1:0]  fu_op_o;
  logic [DW-1:0]  fu_a_o;
  logic [DW-1:0]  fu_b_o;
  logic [NF-1:0]  fu_busy_i;
  logic [NF-1:0]  fu_done_i;
  logic [NF*DW-1:0] fu_result_i;
  logic [NF-1:0]  fu_exc_valid_i;
  logic [NF*32-1:0] fu_exc_cause_i;
  logic [NC-1:0]  cdb_valid_o;
  logic [NC*TW-1:0] cdb_rob_tag_o;
  logic [NC*DW-1:0] cdb_data_o;
  logic [NC-1:0]  cdb_exc_valid_o;
  logic [NC*32-1:0] cdb_exc_cause_o;
  logic           overflow_err_o;

  fu_dispatch_cdb_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_fu_type_i(issue_fu_type_i), .issue_op_i(issue_op_i),
    .issue_a_i(issue_a_i), .issue_b_i(issue_b_i), .issue_rob_tag_i(issue_rob_tag_i),
    .fu_start_o(fu_start_o), .fu_op_o(fu_op_o), .fu_a_o(fu_a_o), .fu_b_o(fu_b_o),
    .fu_busy_i(fu_busy_i), .fu_done_i(fu_done_i), .fu_result_i(fu_result_i),
    .fu_exc_valid_i(fu_exc_valid_i), .fu_exc_cause_i(fu_exc_cause_i),
    .cdb_valid_o(cdb_valid_o), .cdb_rob_tag_o(cdb_rob_tag_o), .cdb_data_o(cdb_data_o),
    .cdb_exc_valid_o(cdb_exc_valid_o), .cdb_exc_cause_o(cdb_exc_cause_o),
    .overflow_err_o(overflow_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: which slots hold an op / a result, and the rr pointer.
  int          type_of [NF] = '{0, 0, 1, 2};
  bit          m_busy  [NF];
  logic [TW-1:0] m_tag [NF];
  bit          m_held  [NF];
  logic [TW-1:0] m_htag [NF];
  logic [DW-1:0] m_hdata [NF];
  bit          m_hexc  [NF];
  logic [31:0] m_hcause [NF];
  int          m_rr;
  bit          m_ovf;

  always @(negedge clk_i) begin : model
    int          winners[$];
    logic [NF-1:0] es;
    bit          er;
    if (!rst_ni) begin
      for (int f = 0; f < NF; f++) begin
        m_busy[f] = 0;
        m_held[f] = 0;
      end
      m_rr  = 0;
      m_ovf = 0;
      chk("rst_fu_start", 64'(fu_start_o), 64'(0));
      chk("rst_cdb_valid", 64'(cdb_valid_o), 64'(0));
      chk("rst_overflow", 64'(overflow_err_o), 64'(0));
    end else begin
      er = 0;
      es = '0;
      if (!flush_i) begin
        for (int f = 0; f < NF; f++) begin
          if (type_of[f] == int'(issue_fu_type_i) && !fu_busy_i[f] && !m_busy[f] && !m_held[f]) begin
            if (!er) es[f] = 1'b1;
            er = 1;
          end
        end
      end
      if (!issue_valid_i) es = '0;
      chk("issue_ready", 64'(issue_ready_o), 64'(er));
      chk("fu_start", 64'(fu_start_o), 64'(es));
      if (es != '0) begin
        chk("fu_op", 64'(fu_op_o), 64'(issue_op_i));
        chk("fu_a", 64'(fu_a_o), 64'(issue_a_i));
        chk("fu_b", 64'(fu_b_o), 64'(issue_b_i));
      end
      winners.delete();
      if (!flush_i) begin
        for (int i = 0; i < NF; i++) begin
          int s;
          s = (m_rr + i) % NF;
          if (m_held[s] && winners.size() < NC) winners.push_back(s);
        end
      end
      for (int k = 0; k < NC; k++) begin
        logic          ev;
        logic [TW-1:0] et;
        logic [DW-1:0] ed;
        logic          ee;
        logic [31:0]   ec;
        ev = 0; et = '0; ed = '0; ee = 0; ec = '0;
        if (k < winners.size()) begin
          ev = 1;
          et = m_htag[winners[k]];
          ed = m_hdata[winners[k]];
          ee = m_hexc[winners[k]];
          ec = m_hcause[winners[k]];
        end
        chk("cdb_valid", 64'(cdb_valid_o[k]), 64'(ev));
        chk("cdb_tag", 64'(cdb_rob_tag_o[k*TW +: TW]), 64'(et));
        chk("cdb_data", 64'(cdb_data_o[k*DW +: DW]), 64'(ed));
        chk("cdb_exc", 64'(cdb_exc_valid_o[k]), 64'(ee));
        chk("cdb_cause", 64'(cdb_exc_cause_o[k*32 +: 32]), 64'(ec));
      end
      chk("overflow", 64'(overflow_err_o), 64'(m_ovf));
      if (flush_i) begin
        for (int f = 0; f < NF; f++) begin
          m_busy[f] = 0;
          m_held[f] = 0;
        end
        m_rr = 0;
      end else begin
        for (int f = 0; f < NF; f++) begin
          if (fu_done_i[f]) begin
            if (m_held[f]) m_ovf = 1;
            else if (m_busy[f]) begin
              m_busy[f]   = 0;
              m_held[f]   = 1;
              m_htag[f]   = m_tag[f];
              m_hdata[f]  = fu_result_i[f*DW +: DW];
              m_hexc[f]   = fu_exc_valid_i[f];
              m_hcause[f] = fu_exc_cause_i[f*32 +: 32];
            end
          end
        end
        foreach (winners[i]) m_held[winners[i]] = 0;
        if (winners.size() > 0) m_rr = (winners[winners.size()-1] + 1) % NF;
        for (int f = 0; f < NF; f++) begin
          if (es[f]) begin
            m_busy[f] = 1;
            m_tag[f]  = issue_rob_tag_i;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clr();
    issue_valid_i  = 0;
    flush_i        = 0;
    fu_done_i      = '0;
    fu_busy_i      = '0;
    fu_exc_valid_i = '0;
  endtask

  task automatic issue(input int t, input int tag);
    issue_valid_i   = 1;
    issue_fu_type_i = 2'(t);
    issue_rob_tag_i = TW'(tag);
    issue_op_i      = OW'($urandom);
    issue_a_i       = $urandom;
    issue_b_i       = $urandom;
  endtask

  task automatic done(input int f, input logic [31:0] v);
    fu_done_i[f]            = 1'b1;
    fu_result_i[f*DW +: DW] = v;
  endtask

  initial begin
    rst_ni = 1;
    clr();
    issue_fu_type_i = '0; issue_op_i = '0; issue_a_i = '0; issue_b_i = '0;
    issue_rob_tag_i = '0; fu_result_i = '0; fu_exc_cause_i = '0;
    #1 rst_ni = 0;
    issue(0, 1);
    look();
    chk("reset_start", 64'(fu_start_o), 64'(0));
    chk("reset_cdb", 64'(cdb_valid_o), 64'(0));
    @(posedge clk_i); #1 rst_ni = 1;
    clr();

    // single op to FU0, result three cycles later
    cyc(); clr(); issue(0, 5); look();
    chk("t1_start", 64'(fu_start_o), 64'(4'b0001));
    chk("t1_ready", 64'(issue_ready_o), 64'(1));
    cyc(); clr();
    cyc(); clr();
    cyc(); clr(); done(0, 32'h1234);
    cyc(); clr(); look();
    chk("t1_cdb_valid", 64'(cdb_valid_o), 64'(2'b01));
    chk("t1_cdb_tag", 64'(cdb_rob_tag_o[TW-1:0]), 64'(5));
    chk("t1_cdb_data", 64'(cdb_data_o[DW-1:0]), 64'(32'h1234));

    // second type0 op goes to FU1, third finds none
    cyc(); clr(); issue(0, 7); look();
    chk("t2_start0", 64'(fu_start_o), 64'(4'b0001));
    cyc(); clr(); issue(0, 6); look();
    chk("t2_start1", 64'(fu_start_o), 64'(4'b0010));
    cyc(); clr(); issue(0, 9); look();
    chk("t2_full_ready", 64'(issue_ready_o), 64'(0));
    chk("t2_full_start", 64'(fu_start_o), 64'(0));
    cyc(); clr(); done(0, 32'hA); done(1, 32'hB);
    cyc(); clr(); look();
    chk("t2_cdb_valid", 64'(cdb_valid_o), 64'(2'b11));
    chk("t2_port0_tag", 64'(cdb_rob_tag_o[TW-1:0]), 64'(6));
    chk("t2_port1_tag", 64'(cdb_rob_tag_o[2*TW-1:TW]), 64'(7));

    // move rr to 0, then four simultaneous results
    cyc(); clr(); issue(2, 0);
    cyc(); clr(); done(3, 32'h0);
    cyc(); clr(); look();
    chk("t3_model_rr0", 64'(m_rr), 64'(0));
    cyc(); clr(); issue(0, 1);
    cyc(); clr(); issue(0, 2);
    cyc(); clr(); issue(1, 3);
    cyc(); clr(); issue(2, 4); look();
    chk("t3_start3", 64'(fu_start_o), 64'(4'b1000));
    cyc(); clr();
    done(0, 32'h11); done(1, 32'h22); done(2, 32'h33); done(3, 32'h44);
    cyc(); clr(); look();
    chk("t3_c1_valid", 64'(cdb_valid_o), 64'(2'b11));
    chk("t3_c1_tags", 64'(cdb_rob_tag_o), 64'({5'd2, 5'd1}));
    chk("t3_c1_data", 64'(cdb_data_o), {32'h22, 32'h11});
    cyc(); clr(); look();
    chk("t3_c2_tags", 64'(cdb_rob_tag_o), 64'({5'd4, 5'd3}));
    chk("t3_c2_data", 64'(cdb_data_o), {32'h44, 32'h33});
    cyc(); clr(); look();
    chk("t3_c3_valid", 64'(cdb_valid_o), 64'(0));
    chk("t3_model_rr_end", 64'(m_rr), 64'(0));

    // two different types complete together, one with an exception
    cyc(); clr(); issue(1, 10);
    cyc(); clr(); issue(2, 11);
    cyc(); clr(); done(2, 32'h55); done(3, 32'h66);
    fu_exc_valid_i[3] = 1'b1; fu_exc_cause_i[3*32 +: 32] = 32'h0;
    cyc(); clr(); look();
    chk("t4_valid", 64'(cdb_valid_o), 64'(2'b11));
    chk("t4_exc", 64'(cdb_exc_valid_o), 64'(2'b10));
    chk("t4_tags", 64'(cdb_rob_tag_o), 64'({5'd11, 5'd10}));

    // flush kills an in-flight op; its late done is ignored
    cyc(); clr(); issue(2, 12); look();
    chk("t5_start", 64'(fu_start_o), 64'(4'b1000));
    cyc(); clr(); flush_i = 1; issue(0, 20); look();
    chk("t5_flush_ready", 64'(issue_ready_o), 64'(0));
    chk("t5_flush_start", 64'(fu_start_o), 64'(0));
    cyc(); clr(); done(3, 32'h77);
    cyc(); clr(); look();
    chk("t5_no_cdb", 64'(cdb_valid_o), 64'(0));
    fu_busy_i[3] = 1'b1; issue(2, 13); look();
    chk("t5_busy_ready", 64'(issue_ready_o), 64'(0));
    cyc(); clr(); issue(2, 13); look();
    chk("t5_reuse_start", 64'(fu_start_o), 64'(4'b1000));
    cyc(); clr(); done(3, 32'h88);
    cyc(); clr(); look();
    chk("t5_cdb_tag", 64'(cdb_rob_tag_o[TW-1:0]), 64'(13));

    // second done while the buffer is still full -> sticky overflow
    cyc(); clr(); issue(0, 14);
    cyc(); clr(); done(0, 32'h1);
    cyc(); clr(); done(0, 32'h2); look();
    chk("t6_ovf_before", 64'(overflow_err_o), 64'(0));
    cyc(); clr(); look();
    chk("t6_ovf_set", 64'(overflow_err_o), 64'(1));
    repeat (3) begin cyc(); clr(); end
    look();
    chk("t6_ovf_sticky", 64'(overflow_err_o), 64'(1));

    // randomized traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      cyc(); clr();
      if (c == 1500) rst_ni = 0;
      if (c == 1502) rst_ni = 1;
      flush_i         = ($urandom_range(0, 39) == 0);
      issue_valid_i   = ($urandom_range(0, 9) < 7);
      issue_fu_type_i = 2'($urandom_range(0, 3));
      issue_rob_tag_i = TW'($urandom);
      issue_op_i      = OW'($urandom);
      issue_a_i       = $urandom;
      issue_b_i       = $urandom;
      for (int f = 0; f < NF; f++) begin
        fu_busy_i[f] = ($urandom_range(0, 4) == 0);
        if (m_busy[f]) fu_done_i[f] = ($urandom_range(0, 2) == 0);
        else           fu_done_i[f] = ($urandom_range(0, 29) == 0);
        fu_result_i[f*DW +: DW]    = $urandom;
        fu_exc_valid_i[f]          = ($urandom_range(0, 9) == 0);
        fu_exc_cause_i[f*32 +: 32] = $urandom;
      end
    end
    cyc(); clr();
    look();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
